bch_syndrome: RTL and testbench
===============================

// Module: bch_syndrome
// PURPOSE
//  Serial syndrome stage of the BCH(63,56) decoder; sits directly upstream of the error-pattern lookup stage.
//  Shifts in a received 63-bit word MSB first and divides it by g(x)=x^7+x^6+x^2+1 in an LFSR.
//  Then presents syndrome S, its weight w and a one-cycle isEn2 strobe to the lookup stage.
//  Also holds the received word R for the downstream corrector (R ^ ep).
// PARAMETERS
//  N      63           codeword length; also the bit-counter terminal count (N-1)
//  RW     7            syndrome width = deg g(x)
//  GPOLY  7'b1000101   g(x) without x^7; bit k = coeff of x^k
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  Din_Valid  in   1   Din carries a valid code bit this cycle
//  Din        in   1   code bit; first bit = r[62], last = r[0]
//  Din_Ready  out  1   stage accepts a bit this cycle
//  S          out  7   syndrome; S[k] = coeff of x^k of r(x) mod g(x)
//  w          out  3   popcount(S), range 0..7
//  isEn2      out  1   one-cycle strobe: S, w, R valid (lookup enable)
//  R          out  63  received word; R[i] = coeff of x^i
// BEHAVIOUR
//  Reset: S=0, w=0, isEn2=0, R=0, Din_Ready=1, lfsr=0, cnt=0, state=IDLE.
//  Reset is honoured in any state; a partial word is discarded, with no strobe.
//  Accept: a bit is taken when Din_Valid && Din_Ready. Gaps with Din_Valid=0 freeze lfsr and cnt.
//  LFSR update on accept: fb = lfsr[6];
//    lfsr <= {lfsr[5:0],Din} ^ (fb ? GPOLY : 7'b0);
//    shreg <= {shreg[61:0],Din}.
//  FSM:
//    IDLE:  Din_Ready=1. On the first accepted bit: lfsr <= {6'b0,Din}, cnt <= 1, go to SHIFT.
//    SHIFT: Din_Ready=1. Accept bits and increment cnt.
//           On the accept with cnt==N-1 (63rd bit), go to DONE.
//    DONE:  Din_Ready=0; inputs are ignored.
//           The cycle after the 63rd accept, S <= lfsr_final, w <= popcount(lfsr_final), R <= shreg_final, isEn2 <= 1.
//           Next cycle: isEn2 <= 0, go to IDLE.
//  Latency: isEn2 is high exactly 1 cycle, in the cycle after the 63rd accepted bit.
//  Throughput: the next word's first bit may be accepted 1 cycle after isEn2 (64 cycles/word minimum).
//  S, w, R hold their values until the next word completes; they do not clear between words.
//  cnt is 6 bits and never wraps inside a word; it is cleared on entering IDLE.
//  Because a single-bit error at i<7 gives w==1, the lookup stage only acts on w>1.
// CONFIGURATION
//  SYND_ERRCNT_EN defined:
//    Adds output Err_Cnt[15:0], reset to 0.
//    Increments in the isEn2 cycle when S!=0; saturates at 16'hFFFF.
//  SYND_ERRCNT_EN undefined:
//    The port and counter are absent; all other behaviour is identical.
// TESTING
//  1. All-zero word, 63 back-to-back bits -> isEn2 at cycle 64; S=7'b0000000, w=0, R=0.
//  2. Single 1 at r[62] (first bit), rest 0 -> S=7'b1100010, w=3, R=63'h4000_0000_0000_0000.
//  3. Single 1 at r[7] -> S=7'b1000101, w=3.
//     Single 1 at r[8] -> S=7'b1001111, w=5.
//  4. Single 1 at r[0] (last bit) -> S=7'b0000001, w=1. Any valid codeword (multiple of g) -> S=0.
//  5. Word 2 with random Din_Valid gaps -> same S/w/R as gap-free.
//     Din_Valid held high in DONE -> bit not consumed (Din_Ready=0).
//  6. rst_n low after 30 bits -> no isEn2, outputs 0.
//     A following full word decodes correctly. With SYND_ERRCNT_EN: 3 words, 2 with nonzero S -> Err_Cnt=2.

Source files
------------

// File: rtl/bch_syndrome.sv
// Serial syndrome stage of the BCH(63,56) decoder: divides r(x) by g(x) MSB first.
// Optional SYND_ERRCNT_EN adds a saturating count of words with nonzero syndrome.
module bch_syndrome #(
    parameter int             N     = 63,
    parameter int             RW    = 7,
    parameter logic [RW-1:0]  GPOLY = 7'b1000101
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Din_Valid,
    input  logic          Din,
    output logic          Din_Ready,
    output logic [RW-1:0] S,
    output logic [2:0]    w,
    output logic          isEn2,
    output logic [N-1:0]  R
`ifdef SYND_ERRCNT_EN
    ,
    output logic [15:0]   Err_Cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [RW-1:0]  lfsr;
    logic [RW-1:0]  lfsr_nxt;
    logic [N-1:0]   shreg;
    logic [N-1:0]   shreg_nxt;
    logic [5:0]     cnt;
    logic           acc;
    logic           last;

    function automatic logic [2:0] popcnt(input logic [RW-1:0] v);
        logic [2:0] pc;
        pc = 3'd0;
        for (int k = 0; k < RW; k++) begin
            pc = pc + 3'(v[k]);
        end
        return pc;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Din_Ready = 1'b1;
        unique case (state)
            IDLE: begin
                if (acc) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                Din_Ready = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign acc       = Din_Valid && Din_Ready;
    assign last      = acc && (state == SHIFT) && (cnt == 6'(N-1));
    assign shreg_nxt = {shreg[N-2:0], Din};

    // The first bit of a word seeds the remainder, so a stale lfsr never leaks in
    always_comb begin
        if (state == IDLE) begin
            lfsr_nxt = {{(RW-1){1'b0}}, Din};
        end else begin
            lfsr_nxt = {lfsr[RW-2:0], Din} ^ (lfsr[RW-1] ? GPOLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= '0;
            shreg <= '0;
            cnt   <= 6'd0;
        end else begin
            if (acc) begin
                lfsr  <= lfsr_nxt;
                shreg <= shreg_nxt;
            end
            if (state == DONE) begin
                cnt <= 6'd0;
            end else if (acc) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S     <= '0;
            w     <= 3'd0;
            R     <= '0;
            isEn2 <= 1'b0;
        end else begin
            isEn2 <= last;
            if (last) begin
                S <= lfsr_nxt;
                w <= popcnt(lfsr_nxt);
                R <= shreg_nxt;
            end
        end
    end

`ifdef SYND_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err_Cnt <= 16'd0;
        end else if (last && (lfsr_nxt != '0) && (Err_Cnt != 16'hFFFF)) begin
            Err_Cnt <= Err_Cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bch_syndrome.sv
// Directed bench for bch_syndrome: hand-computed syndromes of single-bit words,
// codewords, gapped input, mid-word reset and (with SYND_ERRCNT_EN) the error counter.
module tb_bch_syndrome;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Din_Valid = 1'b0;
    logic        Din = 1'b0;
    logic        Din_Ready;
    logic [6:0]  S;
    logic [2:0]  w;
    logic        isEn2;
    logic [62:0] R;
`ifdef SYND_ERRCNT_EN
    logic [15:0] Err_Cnt;
    int          exp_err = 0;
`endif

    int total = 0;
    int passed = 0;
    int early = 0;
    int cyc = 0;

    bch_syndrome dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Din_Valid (Din_Valid),
        .Din       (Din),
        .Din_Ready (Din_Ready),
        .S         (S),
        .w         (w),
        .isEn2     (isEn2),
        .R         (R)
`ifdef SYND_ERRCNT_EN
        ,
        .Err_Cnt   (Err_Cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives r[62] first; leaves Din_Valid high into the DONE cycle
    task automatic send(input logic [62:0] r, input bit gaps);
        early = 0;
        cyc = 0;
        for (int i = 62; i >= 0; i--) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    @(negedge clk);
                    cyc++;
                    Din_Valid = 1'b0;
                    if (isEn2) early++;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            cyc++;
            if (isEn2 || !Din_Ready) early++;
            Din_Valid = 1'b1;
            Din = r[i];
            @(posedge clk);
        end
        @(negedge clk);
        cyc++;
        Din = 1'b1;
    endtask

    task automatic finish(input string tag, input logic [6:0] es,
                          input logic [2:0] ew, input logic [62:0] er,
                          input bit timed);
        if (timed) chk({tag, " cycle"}, 64'(cyc), 64'd64);
        chk({tag, " no_early"}, 64'(early), 64'd0);
        chk({tag, " isEn2"}, 64'(isEn2), 64'd1);
        chk({tag, " ready_done"}, 64'(Din_Ready), 64'd0);
        chk({tag, " S"}, 64'(S), 64'(es));
        chk({tag, " w"}, 64'(w), 64'(ew));
        chk({tag, " R"}, 64'(R), 64'(er));
`ifdef SYND_ERRCNT_EN
        if (es != 7'd0 && exp_err < 65535) exp_err++;
`endif
        @(negedge clk);
        Din_Valid = 1'b0;
        chk({tag, " isEn2_drop"}, 64'(isEn2), 64'd0);
        chk({tag, " ready_back"}, 64'(Din_Ready), 64'd1);
        chk({tag, " S_hold"}, 64'(S), 64'(es));
`ifdef SYND_ERRCNT_EN
        chk({tag, " err_cnt"}, 64'(Err_Cnt), 64'(exp_err));
`endif
    endtask

    initial begin
        #2;
        chk("rst S", 64'(S), 64'd0);
        chk("rst w", 64'(w), 64'd0);
        chk("rst isEn2", 64'(isEn2), 64'd0);
        chk("rst R", 64'(R), 64'd0);
        chk("rst ready", 64'(Din_Ready), 64'd1);
`ifdef SYND_ERRCNT_EN
        chk("rst err_cnt", 64'(Err_Cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        send(63'd0, 1'b0);
        finish("zero", 7'b0000000, 3'd0, 63'd0, 1'b1);

        send(63'h4000_0000_0000_0000, 1'b0);
        finish("r62", 7'b1100010, 3'd3, 63'h4000_0000_0000_0000, 1'b1);

        send(63'h80, 1'b0);
        finish("r7", 7'b1000101, 3'd3, 63'h80, 1'b1);

        send(63'h100, 1'b0);
        finish("r8", 7'b1001111, 3'd5, 63'h100, 1'b1);

        send(63'h1, 1'b0);
        finish("r0", 7'b0000001, 3'd1, 63'h1, 1'b1);

        send(63'hC5, 1'b0);
        finish("cw_g", 7'b0000000, 3'd0, 63'hC5, 1'b1);

        send(63'h18A, 1'b0);
        finish("cw_xg", 7'b0000000, 3'd0, 63'h18A, 1'b1);

        send(63'h4000_0000_0000_0100, 1'b1);
        finish("gaps", 7'b0101101, 3'd4, 63'h4000_0000_0000_0100, 1'b0);

        send(63'h4000_0000_0000_0100, 1'b0);
        finish("nogaps", 7'b0101101, 3'd4, 63'h4000_0000_0000_0100, 1'b1);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            Din_Valid = 1'b1;
            Din = (i % 3) == 0;
            @(posedge clk);
        end
        @(negedge clk);
        Din_Valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst S", 64'(S), 64'd0);
        chk("mid_rst w", 64'(w), 64'd0);
        chk("mid_rst isEn2", 64'(isEn2), 64'd0);
        chk("mid_rst R", 64'(R), 64'd0);
        chk("mid_rst ready", 64'(Din_Ready), 64'd1);
`ifdef SYND_ERRCNT_EN
        exp_err = 0;
        chk("mid_rst err_cnt", 64'(Err_Cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst no_strobe", 64'(isEn2), 64'd0);
        end

        send(63'hC5, 1'b0);
        finish("after_rst cw", 7'b0000000, 3'd0, 63'hC5, 1'b1);
        send(63'h80, 1'b1);
        finish("after_rst r7", 7'b1000101, 3'd3, 63'h80, 1'b0);
        send(63'h1, 1'b0);
        finish("after_rst r0", 7'b0000001, 3'd1, 63'h1, 1'b1);
`ifdef SYND_ERRCNT_EN
        chk("err_cnt final", 64'(Err_Cnt), 64'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
